load_store_unit: RTL and testbench

//  Memory stage between the ALU and the data memory. It takes an ALU-computed byte address, funct3 and

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, byte-enable bases.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal for them.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store replication outbound, lane extract and
// sign/zero extension inbound. Halfwords use a[1] only, words always use lane 0.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [1:0]  sh;
  logic [31:0] lane;

  always_comb begin
    sh      = '0;
    be_o    = BE_W;
    wdata_o = wdata_i;
    rdata_o = '0;
    case (func3_i[1:0])
      2'b00: begin
        sh      = addr_lo_i;
        be_o    = BE_B << sh;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        sh      = {addr_lo_i[1], 1'b0};
        be_o    = BE_H << sh;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        sh      = '0;
        be_o    = BE_W;
        wdata_o = wdata_i;
      end
    endcase

    lane = rdata_i >> {sh, 3'b000};
    case (func3_i)
      F3_LB:   rdata_o = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   rdata_o = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  rdata_o = {24'd0, lane[7:0]};
      F3_LHU:  rdata_o = {16'd0, lane[15:0]};
      default: rdata_o = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one word access per request over a req/ack handshake with timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of ignoring low bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_Valid,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic [2:0]        i_Func3,
  input  logic [31:0]       i_Address,
  input  logic [31:0]       i_WriteData,
  output logic              o_Ready,
  output logic              o_Done,
  output logic [31:0]       o_ReadData,
  output logic              o_Fault,
  output logic              o_MemReq,
  output logic              o_MemWe,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [3:0]        o_MemBe,
  output logic [31:0]       o_MemWData,
  input  logic              i_MemAck,
  input  logic [31:0]       i_MemRData
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]  be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        bad_req;
  logic        unused_addr;

  assign unused_addr = ^i_Address[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_req = f3_illegal(i_Func3, i_MemWrite) || f3_misaligned(i_Func3, i_Address[1:0]);
`else
  assign bad_req = f3_illegal(i_Func3, i_MemWrite);
`endif

  lsu_align u_align (
    .func3_i   (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (i_MemRData),
    .be_o      (be),
    .wdata_o   (st_wdata),
    .rdata_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Valid && (i_MemRead || i_MemWrite)) begin
          addr_d  = i_Address[ADDR_W+1:0];
          f3_d    = i_Func3;
          wdata_d = i_WriteData;
          we_d    = i_MemWrite;
          cnt_d   = '0;
          if (bad_req) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
            fault_d = 1'b0;
          end
        end
      end
      ST_REQ: begin
        // Ack is tested first so an ack on the final allowed cycle still completes cleanly.
        if (i_MemAck) begin
          state_d = ST_RESP;
          fault_d = 1'b0;
          rdata_d = we_q ? '0 : ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Ready    = (state_q == ST_IDLE);
  assign o_Done     = (state_q == ST_RESP);
  assign o_Fault    = o_Done && fault_q;
  assign o_ReadData = rdata_q;
  assign o_MemReq   = (state_q == ST_REQ);
  assign o_MemWe    = o_MemReq && we_q;
  assign o_MemAddr  = addr_q[ADDR_W+1:2];
  assign o_MemBe    = o_MemReq ? be : '0;
  assign o_MemWData = st_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_Valid = 1'b0, i_MemRead = 1'b0, i_MemWrite = 1'b0;
  logic [2:0]  i_Func3 = '0;
  logic [31:0] i_Address = '0, i_WriteData = '0;
  logic        o_Ready, o_Done, o_Fault, o_MemReq, o_MemWe;
  logic [31:0] o_ReadData, o_MemWData;
  logic [4:0]  o_MemAddr;
  logic [3:0]  o_MemBe;
  logic        i_MemAck = 1'b0;
  logic [31:0] i_MemRData = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(5), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .i_Valid(i_Valid), .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_Func3(i_Func3), .i_Address(i_Address), .i_WriteData(i_WriteData),
    .o_Ready(o_Ready), .o_Done(o_Done), .o_ReadData(o_ReadData), .o_Fault(o_Fault),
    .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemBe(o_MemBe),
    .o_MemWData(o_MemWData), .i_MemAck(i_MemAck), .i_MemRData(i_MemRData)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns 1ns after the accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    i_Valid = 1'b1; i_MemRead = rd; i_MemWrite = wr;
    i_Func3 = f3; i_Address = a; i_WriteData = wd;
    tick;
    i_Valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (o_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_Ready); end
    checks++; if ({o_Done, o_Fault, o_MemReq, o_MemWe} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {o_Done, o_Fault, o_MemReq, o_MemWe}); end
    checks++; if (o_MemBe !== 4'b0000) begin errors++; $display("FAIL reset_be got %b want 0000", o_MemBe); end
    checks++; if ({o_ReadData, o_MemWData, o_MemAddr} !== 69'd0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", o_ReadData, o_MemWData, o_MemAddr); end
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_sw;
    issue(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF);
    checks++; if ({o_Ready, o_MemReq, o_MemWe, o_Done} !== 4'b0110) begin errors++; $display("FAIL sw_req_ctrl got %b want 0110", {o_Ready, o_MemReq, o_MemWe, o_Done}); end
    checks++; if (o_MemAddr !== 5'd2) begin errors++; $display("FAIL sw_addr got %0d want 2", o_MemAddr); end
    checks++; if (o_MemBe !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", o_MemBe); end
    checks++; if (o_MemWData !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", o_MemWData); end
    i_MemAck = 1'b1;
    tick;
    i_MemAck = 1'b0;
    checks++; if ({o_Done, o_Fault, o_MemReq} !== 3'b100) begin errors++; $display("FAIL sw_resp got %b want 100", {o_Done, o_Fault, o_MemReq}); end
    tick;
    checks++; if ({o_Ready, o_Done} !== 2'b10) begin errors++; $display("FAIL sw_idle got %b want 10", {o_Ready, o_Done}); end
  endtask

  task automatic test_sb_lb;
    issue(1'b0, 1'b1, 3'b000, 32'h0D, 32'h000000A5);
    checks++; if (o_MemBe !== 4'b0010) begin errors++; $display("FAIL sb_be got %b want 0010", o_MemBe); end
    checks++; if (o_MemWData !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", o_MemWData); end
    i_MemAck = 1'b1; tick; i_MemAck = 1'b0;
    tick;
    issue(1'b1, 1'b0, 3'b000, 32'h0D, 32'h0);
    checks++; if ({o_MemWe, o_MemBe} !== 5'b00010) begin errors++; $display("FAIL lb_req got %b want 00010", {o_MemWe, o_MemBe}); end
    i_MemRData = 32'h0000A500; i_MemAck = 1'b1; tick; i_MemAck = 1'b0;
    checks++; if ({o_Done, o_Fault} !== 2'b10) begin errors++; $display("FAIL lb_done got %b want 10", {o_Done, o_Fault}); end
    checks++; if (o_ReadData !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_rdata got %h want ffffffa5", o_ReadData); end
    tick;
    checks++; if (o_ReadData !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_hold got %h want ffffffa5", o_ReadData); end
  endtask

  task automatic test_sh;
    issue(1'b0, 1'b1, 3'b001, 32'h06, 32'h1234BEEF);
    checks++; if (o_MemBe !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", o_MemBe); end
    checks++; if (o_MemWData !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata got %h want beefbeef", o_MemWData); end
    i_MemAck = 1'b1; tick; i_MemAck = 1'b0;
    tick;
  endtask

  task automatic test_lhu_wait;
    int low = 0;
    int reqs = 0;
    logic seen = 1'b0;
    logic flt = 1'b1;
    logic [31:0] rd = 32'hFFFFFFFF;
    issue(1'b1, 1'b0, 3'b101, 32'h06, 32'h0);
    checks++; if ({o_MemAddr, o_MemBe} !== {5'd1, 4'b1100}) begin errors++; $display("FAIL lhu_req got %0d %b want 1 1100", o_MemAddr, o_MemBe); end
    i_MemRData = 32'h80011234;
    for (int c = 0; c < 50; c++) begin
      if (o_Ready) break;
      low++;
      if (o_Done) begin seen = 1'b1; rd = o_ReadData; flt = o_Fault; end
      i_MemAck = o_MemReq && (reqs == 5);
      if (o_MemReq) reqs++;
      tick;
    end
    i_MemAck = 1'b0;
    checks++; if (low != 7) begin errors++; $display("FAIL lhu_stall got %0d want 7", low); end
    checks++; if ({seen, flt} !== 2'b10) begin errors++; $display("FAIL lhu_done got %b want 10", {seen, flt}); end
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got %h want 00008001", rd); end
  endtask

  task automatic test_timeout;
    int reqs = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    checks++; if (o_MemAddr !== 5'd8) begin errors++; $display("FAIL to_addr got %0d want 8", o_MemAddr); end
    i_MemRData = 32'hFFFFFFFF;
    for (int c = 0; c < 40; c++) begin
      if (!o_MemReq) break;
      reqs++;
      tick;
    end
    checks++; if (reqs != 16) begin errors++; $display("FAIL to_cycles got %0d want 16", reqs); end
    checks++; if ({o_Done, o_Fault, o_MemReq} !== 3'b110) begin errors++; $display("FAIL to_resp got %b want 110", {o_Done, o_Fault, o_MemReq}); end
    checks++; if (o_ReadData !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", o_ReadData); end
    tick;
    checks++; if ({o_Ready, o_Done, o_Fault} !== 3'b100) begin errors++; $display("FAIL to_idle got %b want 100", {o_Ready, o_Done, o_Fault}); end
  endtask

  task automatic test_ack_at_timeout;
    int reqs = 0;
    issue(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
    i_MemRData = 32'h13579BDF;
    for (int c = 0; c < 40; c++) begin
      if (!o_MemReq) break;
      reqs++;
      i_MemAck = (reqs == 16);
      tick;
    end
    i_MemAck = 1'b0;
    checks++; if (reqs != 16) begin errors++; $display("FAIL ackto_cycles got %0d want 16", reqs); end
    checks++; if ({o_Done, o_Fault} !== 2'b10) begin errors++; $display("FAIL ackto_resp got %b want 10", {o_Done, o_Fault}); end
    checks++; if (o_ReadData !== 32'h13579BDF) begin errors++; $display("FAIL ackto_rdata got %h want 13579bdf", o_ReadData); end
    tick;
  endtask

  task automatic test_illegal;
    issue(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    checks++; if ({o_MemReq, o_Done, o_Fault} !== 3'b011) begin errors++; $display("FAIL ill_ld got %b want 011", {o_MemReq, o_Done, o_Fault}); end
    checks++; if (o_ReadData !== 32'h0) begin errors++; $display("FAIL ill_rdata got %h want 0", o_ReadData); end
    tick;
    issue(1'b0, 1'b1, 3'b100, 32'h0, 32'hFF);
    checks++; if ({o_MemReq, o_Done, o_Fault} !== 3'b011) begin errors++; $display("FAIL ill_st got %b want 011", {o_MemReq, o_Done, o_Fault}); end
    tick;
    checks++; if ({o_Ready, o_Fault} !== 2'b10) begin errors++; $display("FAIL ill_idle got %b want 10", {o_Ready, o_Fault}); end
  endtask

  task automatic test_misalign;
    issue(1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if ({o_MemReq, o_Done, o_Fault} !== 3'b011) begin errors++; $display("FAIL mis_trap got %b want 011", {o_MemReq, o_Done, o_Fault}); end
    tick;
`else
    checks++; if ({o_MemReq, o_MemAddr, o_MemBe} !== {1'b1, 5'd0, 4'b1111}) begin errors++; $display("FAIL mis_req got %b %0d %b want 1 0 1111", o_MemReq, o_MemAddr, o_MemBe); end
    i_MemRData = 32'h11223344; i_MemAck = 1'b1; tick; i_MemAck = 1'b0;
    checks++; if ({o_Done, o_Fault} !== 2'b10) begin errors++; $display("FAIL mis_done got %b want 10", {o_Done, o_Fault}); end
    checks++; if (o_ReadData !== 32'h11223344) begin errors++; $display("FAIL mis_rdata got %h want 11223344", o_ReadData); end
    tick;
`endif
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    checks++; if (o_MemReq !== 1'b1) begin errors++; $display("FAIL rst_pre got %b want 1", o_MemReq); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({o_MemReq, o_Ready, o_Done} !== 3'b010) begin errors++; $display("FAIL rst_async got %b want 010", {o_MemReq, o_Ready, o_Done}); end
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (o_Done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_nodone got %0d want 0", dones); end
    issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D);
    checks++; if ({o_MemAddr, o_MemBe, o_MemWData} !== {5'd4, 4'b1111, 32'hCAFEF00D}) begin errors++; $display("FAIL rst_sw got %0d %b %h want 4 1111 cafef00d", o_MemAddr, o_MemBe, o_MemWData); end
    i_MemAck = 1'b1; tick; i_MemAck = 1'b0;
    checks++; if ({o_Done, o_Fault} !== 2'b10) begin errors++; $display("FAIL rst_sw_done got %b want 10", {o_Done, o_Fault}); end
    tick;
    checks++; if (o_Ready !== 1'b1) begin errors++; $display("FAIL rst_sw_idle got %b want 1", o_Ready); end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_sb_lb;
    test_sh;
    test_lhu_wait;
    test_timeout;
    test_ack_at_timeout;
    test_illegal;
    test_misalign;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
